// File: rtl/inst_fifo.sv
// Instruction queue between icache return and decode: 0-2 pushes and 0-2 pops per cycle.
// Optional same-cycle bypass into the head ports when empty: define INST_FIFO_BYPASS_EN.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       push_valid,
    input  logic [31:0]      push_inst0,
    input  logic [31:0]      push_pc0,
    input  logic [31:0]      push_inst1,
    input  logic [31:0]      push_pc1,
    output logic             push_accept,
    input  logic [1:0]       pop_cnt,
    output logic             head0_valid,
    output logic [31:0]      head0_inst,
    output logic [31:0]      head0_pc,
    output logic             head1_valid,
    output logic [31:0]      head1_inst,
    output logic [31:0]      head1_pc,
    output logic [PTR_W:0]   count,
    output logic             fifo_full,
    output logic             fifo_1_left,
    output logic             fifo_2_left
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0]       n_push, pop_req, n_pop, n_store;
    logic [PTR_W:0]   free_slots;
    logic             accept, byp;
    logic             wr0_en, wr1_en;
    logic [31:0]      wr0_inst, wr0_pc;
    logic [PTR_W-1:0] rd_p1, wr_p1;

    assign rd_p1 = rd_ptr_q + PTR_W'(1);
    assign wr_p1 = wr_ptr_q + PTR_W'(1);

    always_comb begin
        n_push = 2'd0;
        case (push_valid)
            2'b01:   n_push = 2'd1;
            2'b11:   n_push = 2'd2;
            default: n_push = 2'd0;
        endcase
        pop_req    = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        // Room is judged on the pre-pop occupancy; a same-cycle pop never makes space.
        free_slots = DEPTH_C - count_q;
        accept     = !reset && !flush && (n_push != 2'd0)
                     && (free_slots >= {{(PTR_W-1){1'b0}}, n_push});
    end

`ifdef INST_FIFO_BYPASS_EN
    assign byp = !reset && !flush && (n_push != 2'd0) && (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        if (byp) begin
            n_pop = (pop_req < n_push) ? pop_req : n_push;
        end else if ({{(PTR_W-1){1'b0}}, pop_req} <= count_q) begin
            n_pop = pop_req;
        end else begin
            n_pop = count_q[1:0];
        end

        n_store  = accept ? (byp ? n_push - n_pop : n_push) : 2'd0;
        wr0_en   = (n_store != 2'd0);
        wr1_en   = (n_store == 2'd2);
        // A bypassed word0 consumed by decode leaves word1 as the oldest stored entry.
        wr0_inst = (byp && n_pop == 2'd1) ? push_inst1 : push_inst0;
        wr0_pc   = (byp && n_pop == 2'd1) ? push_pc1   : push_pc0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(n_store);
            rd_ptr_d = byp ? rd_ptr_q : rd_ptr_q + PTR_W'(n_pop);
            count_d  = count_q + (PTR_W+1)'(n_store) - (byp ? '0 : (PTR_W+1)'(n_pop));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            if (wr0_en) begin
                inst_q[wr_ptr_q] <= wr0_inst;
                pc_q[wr_ptr_q]   <= wr0_pc;
            end
            if (wr1_en) begin
                inst_q[wr_p1] <= push_inst1;
                pc_q[wr_p1]   <= push_pc1;
            end
        end
    end

    always_comb begin
        head0_valid = 1'b0;
        head0_inst  = '0;
        head0_pc    = '0;
        head1_valid = 1'b0;
        head1_inst  = '0;
        head1_pc    = '0;
        if (byp) begin
            head0_valid = 1'b1;
            head0_inst  = push_inst0;
            head0_pc    = push_pc0;
            if (n_push == 2'd2) begin
                head1_valid = 1'b1;
                head1_inst  = push_inst1;
                head1_pc    = push_pc1;
            end
        end else begin
            if (count_q >= (PTR_W+1)'(1)) begin
                head0_valid = 1'b1;
                head0_inst  = inst_q[rd_ptr_q];
                head0_pc    = pc_q[rd_ptr_q];
            end
            if (count_q >= (PTR_W+1)'(2)) begin
                head1_valid = 1'b1;
                head1_inst  = inst_q[rd_p1];
                head1_pc    = pc_q[rd_p1];
            end
        end
    end

    assign push_accept = accept;
    assign count       = count_q;
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_1_left = (count_q == DEPTH_C - (PTR_W+1)'(1));
    assign fifo_2_left = (count_q == DEPTH_C - (PTR_W+1)'(2));

endmodule
